fusion_logic_sched: RTL
=======================

// Module: fusion_logic_sched
// PURPOSE
//  Two-requester scheduler for the shared 32-bit bitwise logic unit (XOR/AND/OR/NOR) in the ALU.
//  Arbitrates between issue slots 0 and 1 round-robin and issues one operation per cycle.
//  Registers the result in a one-entry output stage with a valid/ready handshake to writeback.
//  Tags each result with the ID of the requester that issued it.
// PARAMETERS
//  WIDTH     32  operand/result width in bits
//  CNT_W     16  width of the saturating per-requester grant counters
// PORTS
//  clk          in   1      system clock; all state changes on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  req0_valid   in   1      slot 0 has an operation
//  req0_ready   out  1      slot 0 operation accepted this cycle
//  req0_op      in   2      00 XOR, 01 AND, 10 OR, 11 NOR
//  req0_a       in   WIDTH  operand A
//  req0_b       in   WIDTH  operand B
//  req1_*       -    -      identical set for slot 1
//  res_valid    out  1      result register holds a result
//  res_ready    in   1      writeback consumes result this cycle
//  res_data     out  WIDTH  registered result
//  res_id       out  1      requester that produced res_data
//  grant_cnt0   out  CNT_W  saturating count of slot 0 grants
//  grant_cnt1   out  CNT_W  saturating count of slot 1 grants
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): res_valid=0, res_data=0, res_id=0, grant counters=0, last_grant=1.
//  - can_issue = !res_valid | res_ready (output stage empty or draining this cycle).
//  - Arbitration: if exactly one reqN_valid, it wins; if both, winner = !last_grant.
//  - reqN_ready = can_issue & (winner==N) & reqN_valid; never asserted for the loser. Combinational.
//  - Transfer on reqN_valid & reqN_ready: next cycle res_valid=1, res_data=op(a,b), res_id=N,
//    last_grant=N, grant_cntN += 1 (holds at all-ones, no wrap). Latency: accept -> res_valid 1 cycle.
//  - res_valid & res_ready & no new issue: res_valid->0; res_data/res_id hold last value.
//  - res_valid & !res_ready: res_data/res_id/res_valid held stable; both reqN_ready=0.
//  - Simultaneous drain and issue: back-to-back, full throughput 1 op/cycle.
//  - last_grant updates only on an actual transfer; a lone requester does not lose fairness.
//  - Requesters must hold valid/op/operands stable until ready; block does not sample early.
//  - States: EMPTY (res_valid=0) -> FULL on issue; FULL -> EMPTY on drain w/o issue;
//    FULL -> FULL on drain+issue or stall. No other state.
//  - Reset mid-stall: result discarded, res_valid=0 next cycle, arbitration restarts favouring slot 0.
//  - NOR result = ~(a|b) over full WIDTH; no sign/width extension anywhere.
// CONFIGURATION
//  - FUSION_LOGIC_PARITY_EN defined: extra output res_parity (1 bit) = even parity (XOR-reduce)
//    of res_data, registered with res_data, reset 0, held on stall.
//  - Undefined: port res_parity absent; all other behaviour identical.
// STRUCTURE
//  - fusion_alu_pkg: logic_op_t enum (LOP_XOR=0, LOP_AND=1, LOP_OR=2, LOP_NOR=3),
//    LOGIC_WIDTH=32 default constant, requester ID type.
//  - Sub-module fusion_logic_unit: purely combinational op/a/b -> result mux over bitwise ops;
//    scheduler instantiates once and muxes winner operands into it.
//  - Arbiter, output register and counters stay in this module.
// TESTING
//  1. Reset, then req0 XOR a=0xFFFF0000 b=0x0F0F0F0F, res_ready=1 -> next cycle res_valid=1,
//     res_data=0xF0F00F0F, res_id=0, grant_cnt0=1.
//  2. Both valid every cycle, res_ready=1, ops AND 0xFFFFFFFF/0x12345678 -> grants alternate
//     0,1,0,1 starting with 0; results 0x12345678 each, one per cycle.
//  3. res_ready=0 with result held 3 cycles, both requesters valid -> req*_ready=0, res_data stable;
//     res_ready=1 -> drain and new issue same cycle, no bubble.
//  4. NOR a=0 b=0 -> 0xFFFFFFFF; OR a=0x80000000 b=1 -> 0x80000001 (parity 0 when macro set).
//  5. Preload-free saturation: CNT_W=4, 20 slot-1 grants -> grant_cnt1 stops at 15.
//  6. Assert rst_n=0 while FULL and stalled -> next cycle res_valid=0, counters 0; first
//     contested grant after reset goes to slot 0.

Source files
------------

// File: rtl/fusion_alu_pkg.sv
// fusion_alu_pkg: shared types and constants for the fusion ALU logic path.
package fusion_alu_pkg;
  localparam int LOGIC_WIDTH = 32;
  typedef enum logic [1:0] {
    LOP_XOR = 2'd0,
    LOP_AND = 2'd1,
    LOP_OR  = 2'd2,
    LOP_NOR = 2'd3
  } logic_op_t;
  typedef logic req_id_t;
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } sched_state_t;
endpackage

// File: rtl/fusion_logic_unit.sv
// fusion_logic_unit: combinational bitwise XOR/AND/OR/NOR over the full operand width.
module fusion_logic_unit
  import fusion_alu_pkg::*;
#(
  parameter int WIDTH = LOGIC_WIDTH
) (
  input  logic_op_t        op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
);
  assign result_o = op_i == LOP_XOR ? a_i ^ b_i :
                    op_i == LOP_AND ? a_i & b_i :
                    op_i == LOP_OR  ? a_i | b_i : ~(a_i | b_i);
endmodule

// File: rtl/fusion_logic_sched.sv
// fusion_logic_sched: round-robin two-slot scheduler feeding one logic unit into a one-entry result stage.
// Optional FUSION_LOGIC_PARITY_EN adds a registered even-parity output res_parity.
module fusion_logic_sched
  import fusion_alu_pkg::*;
#(
  parameter int WIDTH = LOGIC_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output req_id_t          res_id,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`ifdef FUSION_LOGIC_PARITY_EN
  ,
  output logic             res_parity
`endif
);
  sched_state_t     state_q, state_d;
  req_id_t          winner, last_grant_q, id_q;
  logic             can_issue, issue;
  logic [WIDTH-1:0] data_q, result;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  // Contested cycles go to the slot that did not win the last transfer.
  assign can_issue  = !res_valid || res_ready;
  assign winner     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign req0_ready = can_issue && req0_valid && !winner;
  assign req1_ready = can_issue && req1_valid && winner;
  assign issue      = req0_ready || req1_ready;
  fusion_logic_unit #(.WIDTH(WIDTH)) u_unit (
    .op_i    (logic_op_t'(winner ? req1_op : req0_op)),
    .a_i     (winner ? req1_a : req0_a),
    .b_i     (winner ? req1_b : req0_b),
    .result_o(result)
  );
  always_ff @(posedge clk) begin
    state_q <= !rst_n ? ST_EMPTY : state_d;
  end
  always_comb begin
    state_d = issue ? ST_FULL : (state_q == ST_FULL && !res_ready) ? ST_FULL : ST_EMPTY;
  end
  always_comb begin
    res_valid = state_q == ST_FULL;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q       <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else if (issue) begin
      data_q       <= result;
      id_q         <= winner;
      last_grant_q <= winner;
      cnt0_q       <= (!winner && !(&cnt0_q)) ? cnt0_q + CNT_W'(1) : cnt0_q;
      cnt1_q       <= (winner && !(&cnt1_q)) ? cnt1_q + CNT_W'(1) : cnt1_q;
    end
  end
  assign res_data   = data_q;
  assign res_id     = id_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`ifdef FUSION_LOGIC_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk) begin
    if (!rst_n) parity_q <= 1'b0;
    else if (issue) parity_q <= ^result;
  end
  assign res_parity = parity_q;
`endif
endmodule
